case_stream_buffer: RTL and testbench

- Streaming front-end for the combinational toUpper converter.
- Accepts 8-bit characters over a valid/ready handshake and converts each one to upper case as it is written.
- Stores converted characters in a small FIFO and presents them downstream over a second valid/ready interface.
- Decouples the character producer (UART RX / test driver) from the consumer and absorbs consumer back-pressure.

---
 rtl/case_stream_pkg.sv | 18 +
 rtl/case_stream_buffer_to_upper.sv | 24 ++
 rtl/case_stream_buffer.sv | 151 +++++++++++++++
 tb/tb_case_stream_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/case_stream_pkg.sv
// ---------------------------------------------------------------------------
// case_stream_pkg
// Shared definitions for the case_stream_buffer slice: the ASCII constants
// used by the toUpper converter and the layout of one FIFO entry.
// No ports (package only).
// ---------------------------------------------------------------------------
package case_stream_pkg;

    localparam logic [7:0] ASCII_LOWER_A = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z = 8'd122;
    localparam logic [7:0] CASE_OFFSET   = 8'd32;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } char_entry_t;

endpackage

// File: rtl/case_stream_buffer_to_upper.sv
// ---------------------------------------------------------------------------
// toUpper
// Purely combinational ASCII lower-to-upper case converter.
// Ports:
//   i_char  input  [7:0]  raw character
//   o_char  output [7:0]  'a'..'z' mapped to 'A'..'Z', all other codes
//                         (including 128..255) passed through unchanged
// ---------------------------------------------------------------------------
module toUpper
    import case_stream_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [7:0] o_char
);

    logic w_isLower;

    // Only the 26 lower-case letters are shifted down by the case offset.
    always_comb begin
        w_isLower = (i_char >= ASCII_LOWER_A) && (i_char <= ASCII_LOWER_Z);
        o_char    = w_isLower ? (i_char - CASE_OFFSET) : i_char;
    end

endmodule

// File: rtl/case_stream_buffer.sv
// ---------------------------------------------------------------------------
// case_stream_buffer
// Streaming front-end for the toUpper converter: characters arriving over a
// valid/ready handshake are upper-cased on the way in, buffered in a small
// FIFO and presented downstream over a second valid/ready handshake.
//
// Ports:
//   clk        input   single clock, rising edge
//   rst        input   synchronous active-high reset
//   in_valid   input   producer has a character
//   in_ready   output  buffer can accept (!full, from registered level)
//   in_data    input   [7:0] raw character
//   in_last    input   marks final character of a line/packet
//   out_valid  output  head entry available (!empty)
//   out_ready  input   consumer accepts head entry
//   out_data   output  [7:0] upper-cased character (0 when empty)
//   out_last   output  last flag carried with the character (0 when empty)
//   level      output  [$clog2(DEPTH):0] occupancy 0..DEPTH
//
// Optional macro CASE_STREAM_STATS_EN adds saturating 16-bit counters:
//   chars_total, chars_converted, lines_total.
// ---------------------------------------------------------------------------
module case_stream_buffer
    import case_stream_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   level
`ifdef CASE_STREAM_STATS_EN
    ,
    output logic [15:0]              chars_total,
    output logic [15:0]              chars_converted,
    output logic [15:0]              lines_total
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    char_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [LVL_W-1:0]   r_level;

    logic [7:0]         w_upper;
    logic               w_push;
    logic               w_pop;
    char_entry_t        w_head;

    toUpper u_toUpper (
        .i_char (in_data),
        .o_char (w_upper)
    );

    // Handshake qualifiers. Readiness comes only from the registered level,
    // so a pop in the same cycle never opens a slot for a push while full.
    always_comb begin
        in_ready  = (r_level != FULL_LEVEL);
        out_valid = (r_level != '0);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
    end

    // Combinational head read; outputs are forced to zero when empty so the
    // consumer never sees stale RAM contents.
    always_comb begin
        w_head   = r_mem[r_rdPtr];
        out_data = out_valid ? w_head.data : '0;
        out_last = out_valid ? w_head.last : 1'b0;
        level    = r_level;
    end

    // Storage write. The RAM itself is never cleared; a reset only has to
    // move the pointers, and a push coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wrPtr] <= '{last: in_last, data: w_upper};
        end
    end

    // Pointer and occupancy bookkeeping. Pointers wrap by plain overflow
    // because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

`ifdef CASE_STREAM_STATS_EN
    logic [15:0] r_charsTotal;
    logic [15:0] r_charsConverted;
    logic [15:0] r_linesTotal;
    logic        w_converted;

    always_comb begin
        w_converted = (w_upper != in_data);
    end

    // Traffic statistics; each counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_charsTotal     <= '0;
            r_charsConverted <= '0;
            r_linesTotal     <= '0;
        end else if (w_push) begin
            if (r_charsTotal != 16'hFFFF) begin
                r_charsTotal <= r_charsTotal + 16'd1;
            end
            if (w_converted && r_charsConverted != 16'hFFFF) begin
                r_charsConverted <= r_charsConverted + 16'd1;
            end
            if (in_last && r_linesTotal != 16'hFFFF) begin
                r_linesTotal <= r_linesTotal + 16'd1;
            end
        end
    end

    always_comb begin
        chars_total     = r_charsTotal;
        chars_converted = r_charsConverted;
        lines_total     = r_linesTotal;
    end
`endif

endmodule

// File: tb/tb_case_stream_buffer.sv
// ---------------------------------------------------------------------------
// tb_case_stream_buffer
// Self-checking bench for case_stream_buffer (DEPTH=8). A queue-based model
// of the FIFO with an arithmetic upper-case reference supplies expectations.
// ---------------------------------------------------------------------------
module tb_case_stream_buffer;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [3:0] level;
`ifdef CASE_STREAM_STATS_EN
    logic [15:0] chars_total;
    logic [15:0] chars_converted;
    logic [15:0] lines_total;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] model [$];

    case_stream_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level)
`ifdef CASE_STREAM_STATS_EN
        ,
        .chars_total     (chars_total),
        .chars_converted (chars_converted),
        .lines_total     (lines_total)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference conversion straight from the character-code rule.
    function automatic logic [7:0] refUpper(input logic [7:0] c);
        int v;
        v = c;
        if (v >= 97 && v <= 122) v = v - 32;
        return v[7:0];
    endfunction

    // Drives one clock cycle of stimulus and advances the model; returns at
    // the following falling edge, where the tests sample DUT outputs.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l,
                         input logic r, input logic rs);
        bit doPush;
        bit doPop;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        rst       = rs;
        doPush = !rs && v && (model.size() < DEPTH);
        doPop  = !rs && r && (model.size() > 0);
        @(posedge clk);
        if (rs) begin
            model.delete();
        end else begin
            if (doPop) void'(model.pop_front());
            if (doPush) model.push_back({l, refUpper(d)});
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    // Reset state of every output.
    task automatic test_reset();
        doReset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_data got %0d want 0", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got %0b want 0", out_last); end
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL reset_level got %0d want 0", level); end
    endtask

    // One 'a' through the buffer, then popped.
    task automatic test_single();
        cycle(1'b1, 8'd97, 1'b0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b want 1", out_valid); end
        checks++; if (out_data !== 8'd65) begin errors++; $display("[TB] FAIL single_data got %0d want 65", out_data); end
        checks++; if (level !== 4'd1) begin errors++; $display("[TB] FAIL single_level got %0d want 1", level); end
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL single_drain_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain_valid got %0b want 0", out_valid); end
    endtask

    // Boundary characters around 'a'..'z' and in the upper half.
    task automatic test_stream();
        logic [7:0] inTab  [7] = '{8'd40, 8'd72, 8'd183, 8'd122, 8'd123, 8'd127, 8'd235};
        logic [7:0] expTab [7] = '{8'd40, 8'd72, 8'd183, 8'd90, 8'd123, 8'd127, 8'd235};
        doReset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, inTab[i], (i == 6), 1'b1, 1'b0);
            checks++; if (out_data !== expTab[i]) begin errors++; $display("[TB] FAIL stream_data[%0d] got %0d want %0d", i, out_data, expTab[i]); end
            checks++; if (out_last !== (i == 6)) begin errors++; $display("[TB] FAIL stream_last[%0d] got %0b want %0b", i, out_last, (i == 6)); end
        end
`ifdef CASE_STREAM_STATS_EN
        checks++; if (chars_converted !== 16'd1) begin errors++; $display("[TB] FAIL stats_converted got %0d want 1", chars_converted); end
        checks++; if (chars_total !== 16'd7) begin errors++; $display("[TB] FAIL stats_total got %0d want 7", chars_total); end
        checks++; if (lines_total !== 16'd1) begin errors++; $display("[TB] FAIL stats_lines got %0d want 1", lines_total); end
`endif
        cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL stream_end_level got %0d want 0", level); end
    endtask

    // Fill to full with the consumer stalled, then pop-while-push at full.
    task automatic test_full();
        doReset();
        for (int i = 0; i < 9; i++) begin
            checks++; if (in_ready !== (i < 8)) begin errors++; $display("[TB] FAIL full_in_ready[%0d] got %0b want %0b", i, in_ready, (i < 8)); end
            cycle(1'b1, 8'(97 + i), 1'b0, 1'b0, 1'b0);
        end
        checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL full_level got %0d want 8", level); end
        checks++; if (out_data !== 8'd65) begin errors++; $display("[TB] FAIL full_head got %0d want 65", out_data); end
        // Push and pop together at full: only the pop happens.
        cycle(1'b1, 8'd105, 1'b0, 1'b1, 1'b0);
        checks++; if (level !== 4'd7) begin errors++; $display("[TB] FAIL fullpop_level got %0d want 7", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fullpop_in_ready got %0b want 1", in_ready); end
        cycle(1'b1, 8'd105, 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 4'd8) begin errors++; $display("[TB] FAIL fullpush_level got %0d want 8", level); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (out_data !== 8'(66 + i)) begin errors++; $display("[TB] FAIL drain_data[%0d] got %0d want %0d", i, out_data, 66 + i); end
            cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty got %0b want 0", out_valid); end
    endtask

    // Random handshakes against the queue model.
    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        logic [7:0] d;
        logic l;
        logic v;
        logic r;
        doReset();
        d = 8'($urandom);
        l = 1'($urandom);
        while (sent < 2000 && cyc < 20000) begin
            v = 1'($urandom);
            r = 1'($urandom);
            if (v && model.size() < DEPTH) sent++;
            cycle(v, d, l, r, 1'b0);
            cyc++;
            if (v && in_ready !== 1'bx && model.size() > 0 && model[model.size()-1] === {l, refUpper(d)}) begin
                d = d;
            end
            if (sent > 0 && v) begin
                d = 8'($urandom);
                l = 1'($urandom);
            end
            checks++;
            if (level !== 4'(model.size()) || level > 4'd8) begin
                errors++; $display("[TB] FAIL rand_level got %0d want %0d", level, model.size());
            end
            checks++;
            if (model.size() == 0) begin
                if (out_valid !== 1'b0 || out_data !== 8'd0 || out_last !== 1'b0) begin
                    errors++; $display("[TB] FAIL rand_empty got v=%0b d=%0d l=%0b want 0/0/0", out_valid, out_data, out_last);
                end
            end else if (out_valid !== 1'b1 || {out_last, out_data} !== model[0]) begin
                errors++; $display("[TB] FAIL rand_head got v=%0b %0h want 1 %0h", out_valid, {out_last, out_data}, model[0]);
            end
        end
        checks++;
        if (sent < 2000) begin
            errors++; $display("[TB] FAIL rand_budget sent %0d want 2000", sent);
        end
    endtask

    // Reset arriving with entries stored and a push/pop pending.
    task automatic test_reset_midstream();
        doReset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(100 + i), 1'b0, 1'b0, 1'b0);
        checks++; if (level !== 4'd5) begin errors++; $display("[TB] FAIL mid_prefill got %0d want 5", level); end
        cycle(1'b1, 8'd120, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        checks++; if (level !== 4'd0) begin errors++; $display("[TB] FAIL mid_level got %0d want 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready got %0b want 1", in_ready); end
        cycle(1'b1, 8'd109, 1'b0, 1'b0, 1'b0);
        checks++; if (out_data !== 8'd77) begin errors++; $display("[TB] FAIL mid_after got %0d want 77", out_data); end
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        test_reset();
        test_single();
        test_stream();
        test_full();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
